dram_page_scheduler: RTL and testbench

//   Open-page DRAM command sequencer between a single-request port (fed by the
//   AXI slave side) and the DRAM pin interface. Decodes row = addr[22:12] and
//   col = addr[11:2], and skips PRECHARGE/ACTIVATE on row hits.

---
 rtl/dram_page_scheduler.sv | 204 ++++++++++++++++++++
 tb/tb_dram_page_scheduler.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/dram_page_scheduler.sv
`timescale 1ns/1ps
// Open-page DRAM command sequencer: turns single requests into ACT/PRE/RD/WR
// pin commands, reusing the open row on hits and closing it after an idle timeout.
module dram_page_scheduler #(
   parameter int T_RP       = 5,
   parameter int T_RCD      = 5,
   parameter int T_WR       = 5,
   parameter int IDLE_CLOSE = 16
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_write,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   input  logic [3:0]  req_web,
   output logic        rsp_valid,
   output logic [31:0] rsp_rdata,
   output logic        row_open,
   output logic        DRAM_CSn,
   output logic        DRAM_RASn,
   output logic        DRAM_CASn,
   output logic [3:0]  DRAM_WEn,
   output logic [10:0] DRAM_A,
   output logic [31:0] DRAM_D,
   input  logic        DRAM_valid,
   input  logic [31:0] DRAM_Q
);

   localparam logic [3:0] RP_LOAD  = 4'(T_RP - 1);
   localparam logic [3:0] RCD_LOAD = 4'(T_RCD - 1);
   localparam logic [3:0] WR_LOAD  = 4'(T_WR - 1);
   localparam logic [7:0] IDLE_LIM = 8'(IDLE_CLOSE);

   typedef enum logic [2:0] {IDLE, ACT_W, OPEN, RD_W, WR_W, PRE_W, PRE_I} state_t;

   state_t      state;
   logic [3:0]  timer;
   logic [7:0]  idle_cnt;
   logic [10:0] open_row;
   logic [10:0] lat_row;
   logic [9:0]  lat_col;
   logic        lat_write;
   logic [31:0] lat_wdata;
   logic [3:0]  lat_web;

   logic unused_addr_bits;
   assign unused_addr_bits = ^{req_addr[31:23], req_addr[1:0]};

   // Every pin command lasts one cycle; strobes fall back to idle unless re-issued.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= IDLE;
         timer     <= 4'd0;
         idle_cnt  <= 8'd0;
         open_row  <= 11'd0;
         lat_row   <= 11'd0;
         lat_col   <= 10'd0;
         lat_write <= 1'b0;
         lat_wdata <= 32'd0;
         lat_web   <= 4'hf;
         req_ready <= 1'b0;
         rsp_valid <= 1'b0;
         rsp_rdata <= 32'd0;
         row_open  <= 1'b0;
         DRAM_CSn  <= 1'b0;
         DRAM_RASn <= 1'b1;
         DRAM_CASn <= 1'b1;
         DRAM_WEn  <= 4'hf;
         DRAM_A    <= 11'd0;
         DRAM_D    <= 32'd0;
      end else begin
         DRAM_CSn  <= 1'b0;
         DRAM_RASn <= 1'b1;
         DRAM_CASn <= 1'b1;
         DRAM_WEn  <= 4'hf;
         rsp_valid <= 1'b0;
         case (state)
            IDLE: begin
               req_ready <= 1'b1;
               if (req_valid && req_ready) begin
                  lat_row   <= req_addr[22:12];
                  lat_col   <= req_addr[11:2];
                  lat_write <= req_write;
                  lat_wdata <= req_wdata;
                  lat_web   <= req_web;
                  req_ready <= 1'b0;
                  DRAM_RASn <= 1'b0;
                  DRAM_A    <= req_addr[22:12];
                  open_row  <= req_addr[22:12];
                  row_open  <= 1'b1;
                  timer     <= RCD_LOAD;
                  state     <= ACT_W;
               end
            end
            ACT_W: begin
               if (timer == 4'd0) begin
                  DRAM_CASn <= 1'b0;
                  DRAM_A    <= {1'b0, lat_col};
                  if (lat_write) begin
                     DRAM_WEn <= lat_web;
                     DRAM_D   <= lat_wdata;
                     timer    <= WR_LOAD;
                     state    <= WR_W;
                  end else begin
                     state    <= RD_W;
                  end
               end else begin
                  timer <= timer - 4'd1;
               end
            end
            // A request on the idle terminal-count cycle takes priority over closing.
            OPEN: begin
               if (req_valid && req_ready) begin
                  lat_row   <= req_addr[22:12];
                  lat_col   <= req_addr[11:2];
                  lat_write <= req_write;
                  lat_wdata <= req_wdata;
                  lat_web   <= req_web;
                  req_ready <= 1'b0;
                  idle_cnt  <= 8'd0;
                  if (req_addr[22:12] == open_row) begin
                     DRAM_CASn <= 1'b0;
                     DRAM_A    <= {1'b0, req_addr[11:2]};
                     if (req_write) begin
                        DRAM_WEn <= req_web;
                        DRAM_D   <= req_wdata;
                        timer    <= WR_LOAD;
                        state    <= WR_W;
                     end else begin
                        state    <= RD_W;
                     end
                  end else begin
                     DRAM_RASn <= 1'b0;
                     DRAM_WEn  <= 4'h0;
                     DRAM_A    <= open_row;
                     row_open  <= 1'b0;
                     timer     <= RP_LOAD;
                     state     <= PRE_W;
                  end
               end else if (!req_valid) begin
                  if (idle_cnt == IDLE_LIM) begin
                     DRAM_RASn <= 1'b0;
                     DRAM_WEn  <= 4'h0;
                     DRAM_A    <= open_row;
                     row_open  <= 1'b0;
                     req_ready <= 1'b0;
                     idle_cnt  <= 8'd0;
                     timer     <= RP_LOAD;
                     state     <= PRE_I;
                  end else if (idle_cnt != 8'hff) begin
                     idle_cnt <= idle_cnt + 8'd1;
                  end
               end
            end
            RD_W: begin
               if (DRAM_valid) begin
                  rsp_valid <= 1'b1;
                  rsp_rdata <= DRAM_Q;
                  req_ready <= 1'b1;
                  idle_cnt  <= 8'd0;
                  state     <= OPEN;
               end
            end
            WR_W: begin
               if (timer == 4'd0) begin
                  rsp_valid <= 1'b1;
                  req_ready <= 1'b1;
                  idle_cnt  <= 8'd0;
                  state     <= OPEN;
               end else begin
                  timer <= timer - 4'd1;
               end
            end
            PRE_W: begin
               if (timer == 4'd0) begin
                  DRAM_RASn <= 1'b0;
                  DRAM_A    <= lat_row;
                  open_row  <= lat_row;
                  row_open  <= 1'b1;
                  timer     <= RCD_LOAD;
                  state     <= ACT_W;
               end else begin
                  timer <= timer - 4'd1;
               end
            end
            PRE_I: begin
               if (timer == 4'd0) begin
                  req_ready <= 1'b1;
                  state     <= IDLE;
               end else begin
                  timer <= timer - 4'd1;
               end
            end
            default: begin
               req_ready <= 1'b0;
               state     <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_dram_page_scheduler.sv
`timescale 1ns/1ps
// Directed scoreboard bench for dram_page_scheduler: a default instance covers
// hit/miss/idle-close/reset, a second with IDLE_CLOSE=0 covers close-page mode.
module tb_dram_page_scheduler;

   localparam logic [2:0] C_NONE = 3'd0, C_ACT = 3'd1, C_PRE = 3'd2,
                          C_RD = 3'd3, C_WR = 3'd4, C_BAD = 3'd7;
   localparam logic [84:0] RESET_VEC = {1'b0, 1'b1, 1'b1, 4'hf, 11'd0, 32'd0,
                                        1'b0, 1'b0, 32'd0, 1'b0};

   typedef struct packed {
      logic        wr;
      logic [31:0] data;
   } exp_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst, rst0, sel;
   logic        req_valid, req_write, DRAM_valid;
   logic [31:0] req_addr, req_wdata, DRAM_Q;
   logic [3:0]  req_web;

   logic        aReady, aRspValid, aRowOpen, aCSn, aRASn, aCASn;
   logic [31:0] aRdata, aD;
   logic [3:0]  aWEn;
   logic [10:0] aA;
   logic        bReady, bRspValid, bRowOpen, bCSn, bRASn, bCASn;
   logic [31:0] bRdata, bD;
   logic [3:0]  bWEn;
   logic [10:0] bA;

   logic        o_ready, o_rspValid, o_rowOpen, o_CSn, o_RASn, o_CASn;
   logic [31:0] o_rdata, o_D;
   logic [3:0]  o_WEn;
   logic [10:0] o_A;

   exp_t sb[$];
   int   nCompared = 0;
   int   nMismatched = 0;

   dram_page_scheduler dut (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(aReady),
      .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
      .req_web(req_web), .rsp_valid(aRspValid), .rsp_rdata(aRdata),
      .row_open(aRowOpen), .DRAM_CSn(aCSn), .DRAM_RASn(aRASn), .DRAM_CASn(aCASn),
      .DRAM_WEn(aWEn), .DRAM_A(aA), .DRAM_D(aD), .DRAM_valid(DRAM_valid),
      .DRAM_Q(DRAM_Q)
   );

   dram_page_scheduler #(.IDLE_CLOSE(0)) dut0 (
      .clk(clk), .rst(rst0), .req_valid(req_valid), .req_ready(bReady),
      .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
      .req_web(req_web), .rsp_valid(bRspValid), .rsp_rdata(bRdata),
      .row_open(bRowOpen), .DRAM_CSn(bCSn), .DRAM_RASn(bRASn), .DRAM_CASn(bCASn),
      .DRAM_WEn(bWEn), .DRAM_A(bA), .DRAM_D(bD), .DRAM_valid(DRAM_valid),
      .DRAM_Q(DRAM_Q)
   );

   // Route whichever instance is under test onto one set of observed signals.
   always_comb begin
      o_ready    = sel ? bReady    : aReady;
      o_rspValid = sel ? bRspValid : aRspValid;
      o_rowOpen  = sel ? bRowOpen  : aRowOpen;
      o_CSn      = sel ? bCSn      : aCSn;
      o_RASn     = sel ? bRASn     : aRASn;
      o_CASn     = sel ? bCASn     : aCASn;
      o_rdata    = sel ? bRdata    : aRdata;
      o_D        = sel ? bD        : aD;
      o_WEn      = sel ? bWEn      : aWEn;
      o_A        = sel ? bA        : aA;
   end

   function automatic logic [2:0] cmdKind();
      if (!o_RASn && o_CASn && o_WEn == 4'hf)      return C_ACT;
      else if (!o_RASn && o_CASn && o_WEn == 4'h0) return C_PRE;
      else if (o_RASn && !o_CASn && o_WEn == 4'hf) return C_RD;
      else if (o_RASn && !o_CASn)                  return C_WR;
      else if (o_RASn && o_CASn && o_WEn == 4'hf)  return C_NONE;
      else                                         return C_BAD;
   endfunction

   function automatic logic [84:0] obsVec();
      return {o_CSn, o_RASn, o_CASn, o_WEn, o_A, o_D, o_ready, o_rspValid,
              o_rdata, o_rowOpen};
   endfunction

   task automatic checkOutput(input string tag, input logic [95:0] obs,
                              input logic [95:0] exp);
      nCompared++;
      assert (obs === exp) else begin
         nMismatched++;
         $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
      req_valid = 1'b0;
   endtask

   // Waits for ready, then holds the request for the one cycle that accepts it.
   task automatic applyStimulus(input string tag, input logic wr, input logic [31:0] addr,
                                input logic [31:0] wdata, input logic [3:0] web,
                                input logic [31:0] rdExp);
      int n = 0;
      while (o_ready !== 1'b1 && n < 50) begin
         step();
         n++;
      end
      if (n >= 50) checkOutput({tag, "_ready_timeout"}, 96'(o_ready), 96'd1);
      req_valid = 1'b1;
      req_write = wr;
      req_addr  = addr;
      req_wdata = wdata;
      req_web   = web;
      sb.push_back(exp_t'{wr, rdExp});
   endtask

   task automatic expectCmd(input string tag, input int dly, input logic [2:0] kind,
                            input logic [10:0] a);
      logic early = 1'b0;
      for (int i = 1; i <= dly; i++) begin
         step();
         if (i < dly && cmdKind() != C_NONE) early = 1'b1;
      end
      if (dly > 1) checkOutput({tag, "_quiet"}, 96'(early), 96'd0);
      checkOutput(tag, 96'(cmdKind()), 96'(kind));
      if (kind != C_NONE) checkOutput({tag, "_addr"}, 96'(o_A), 96'(a));
   endtask

   task automatic checkRsp(input string tag);
      exp_t e;
      checkOutput({tag, "_valid"}, 96'(o_rspValid), 96'd1);
      if (sb.size() == 0) begin
         nCompared++;
         nMismatched++;
         $error("[TB] FAIL %s_sb: observed response expected none queued", tag);
      end else begin
         e = sb.pop_front();
         if (!e.wr) checkOutput({tag, "_rdata"}, 96'(o_rdata), 96'(e.data));
      end
   endtask

   task automatic expectAck(input string tag, input int dly);
      logic early = 1'b0;
      for (int i = 1; i <= dly; i++) begin
         step();
         if (i < dly && o_rspValid) early = 1'b1;
      end
      checkOutput({tag, "_early"}, 96'(early), 96'd0);
      checkRsp(tag);
   endtask

   task automatic dramReturn(input string tag, input logic [31:0] q);
      DRAM_Q     = q;
      DRAM_valid = 1'b1;
      step();
      DRAM_valid = 1'b0;
      checkRsp(tag);
   endtask

   initial begin
      #100000;
      $display("[TB] FAIL watchdog: simulation did not finish in time");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      sel = 1'b0; rst = 1'b0; rst0 = 1'b0;
      req_valid = 1'b0; req_write = 1'b0; req_addr = 32'd0; req_wdata = 32'd0;
      req_web = 4'hf; DRAM_valid = 1'b0; DRAM_Q = 32'd0;
      step();
      step();
      checkOutput("reset_values", 96'(obsVec()), 96'(RESET_VEC));
      rst = 1'b1;
      DRAM_Q = 32'h1111_1111; DRAM_valid = 1'b1;
      step();
      DRAM_valid = 1'b0;
      checkOutput("idle_stray_valid", 96'(o_rspValid), 96'd0);

      // Read from IDLE: ACT row 1, RD col 2 five cycles later, two-cycle read latency.
      applyStimulus("t1", 1'b0, 32'h0000_1008, 32'd0, 4'hf, 32'hDEAD_BEEF);
      expectCmd("t1_act", 1, C_ACT, 11'd1);
      checkOutput("t1_row_open", 96'(o_rowOpen), 96'd1);
      expectCmd("t1_rd", 5, C_RD, 11'd2);
      step();
      step();
      dramReturn("t1_rsp", 32'hDEAD_BEEF);
      DRAM_Q = 32'h2222_2222; DRAM_valid = 1'b1;
      step();
      DRAM_valid = 1'b0;
      checkOutput("t1_stray_valid", 96'(o_rspValid), 96'd0);
      checkOutput("t1_rdata_held", 96'(o_rdata), 96'hDEAD_BEEF);

      applyStimulus("t2", 1'b1, 32'h0000_100C, 32'hCAFE_F00D, 4'h0, 32'd0);
      expectCmd("t2_wr", 1, C_WR, 11'd3);
      checkOutput("t2_wdata", 96'(o_D), 96'hCAFE_F00D);
      checkOutput("t2_web", 96'(o_WEn), 96'h0);
      expectAck("t2_ack", 5);

      applyStimulus("t3", 1'b0, 32'h0000_2000, 32'd0, 4'hf, 32'h1234_5678);
      expectCmd("t3_pre", 1, C_PRE, 11'd1);
      checkOutput("t3_row_closed", 96'(o_rowOpen), 96'd0);
      expectCmd("t3_act", 5, C_ACT, 11'd2);
      expectCmd("t3_rd", 5, C_RD, 11'd0);
      dramReturn("t3_rsp", 32'h1234_5678);

      expectCmd("t4_idle_pre", 17, C_PRE, 11'd2);
      checkOutput("t4_row_open", 96'(o_rowOpen), 96'd0);
      checkOutput("t4_ready_pre", 96'(o_ready), 96'd0);
      expectCmd("t4_pre_i", 4, C_NONE, 11'd0);
      checkOutput("t4_ready_wait", 96'(o_ready), 96'd0);
      step();
      checkOutput("t4_ready_back", 96'(o_ready), 96'd1);
      checkOutput("t4_row_open_idle", 96'(o_rowOpen), 96'd0);

      applyStimulus("t5_open", 1'b0, 32'h0000_3004, 32'd0, 4'hf, 32'hA5A5_0001);
      expectCmd("t5_act", 1, C_ACT, 11'd3);
      expectCmd("t5_rd", 5, C_RD, 11'd1);
      dramReturn("t5_rsp", 32'hA5A5_0001);
      expectCmd("t5_wait_tc", 16, C_NONE, 11'd0);
      applyStimulus("t5_tc", 1'b0, 32'h0000_3008, 32'd0, 4'hf, 32'hA5A5_0002);
      expectCmd("t5_tc_rd", 1, C_RD, 11'd2);
      dramReturn("t5_tc_rsp", 32'hA5A5_0002);

      // Reset while waiting for read data: response dropped, row forgotten.
      applyStimulus("t6", 1'b0, 32'h0000_3010, 32'd0, 4'hf, 32'd0);
      expectCmd("t6_rd", 1, C_RD, 11'd4);
      step();
      step();
      rst = 1'b0;
      #1;
      checkOutput("t6_reset_values", 96'(obsVec()), 96'(RESET_VEC));
      DRAM_Q = 32'h3333_3333; DRAM_valid = 1'b1;
      step();
      DRAM_valid = 1'b0;
      sb.delete();
      rst = 1'b1;
      step();
      checkOutput("t6_no_stale_rsp", 96'(o_rspValid), 96'd0);
      applyStimulus("t6_after", 1'b0, 32'h0000_3010, 32'd0, 4'hf, 32'h0BAD_F00D);
      expectCmd("t6_act", 1, C_ACT, 11'd3);
      expectCmd("t6_rd2", 5, C_RD, 11'd4);
      dramReturn("t6_rsp", 32'h0BAD_F00D);

      // Close-page instance: PRE follows every response.
      rst = 1'b0; sel = 1'b1; rst0 = 1'b1;
      step();
      applyStimulus("p0_wr", 1'b1, 32'h0000_5000, 32'h5555_AAAA, 4'h0, 32'd0);
      expectCmd("p0_act", 1, C_ACT, 11'd5);
      expectCmd("p0_wr_cmd", 5, C_WR, 11'd0);
      checkOutput("p0_wdata", 96'(o_D), 96'h5555_AAAA);
      expectAck("p0_ack", 5);
      expectCmd("p0_pre", 1, C_PRE, 11'd5);
      expectCmd("p0_pre_i", 5, C_NONE, 11'd0);
      checkOutput("p0_ready_back", 96'(o_ready), 96'd1);
      applyStimulus("p0_rd", 1'b0, 32'h0000_5004, 32'd0, 4'hf, 32'h0F0F_1234);
      expectCmd("p0_act2", 1, C_ACT, 11'd5);
      expectCmd("p0_rd_cmd", 5, C_RD, 11'd1);
      dramReturn("p0_rsp", 32'h0F0F_1234);
      expectCmd("p0_pre2", 1, C_PRE, 11'd5);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
      $finish;
   end

endmodule
